elastic_delay_pipe: RTL and testbench

- Parametrised successor to the fixed-latency register delay line.
- Carries a WIDTH-bit payload through LATENCY register stages, each with its own valid bit.
- Uses a valid/ready handshake with bubble-collapsing backpressure, plus synchronous flush.
- Used between map-inflation datapath units whose consumers can stall, so no word is lost or duplicated.

---
 rtl/delay_pkg.sv | 9 +
 rtl/elastic_stage.sv | 34 +++
 rtl/elastic_delay_pipe.sv | 102 ++++++++++
 tb/tb_elastic_delay_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared defaults and the occupancy-width helper for the elastic delay pipe.
package delay_pkg;
  localparam int DEFAULT_LATENCY = 4;
  localparam int DEFAULT_WIDTH   = 32;

  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/elastic_stage.sv
// One valid/data register of the elastic delay pipe. Loads whenever it is empty
// or the stage downstream can take its word; flush clears valid but keeps data.
module elastic_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             rdy_in,
  output logic             rdy_out,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty stage always loads, which is what collapses bubbles.
  assign rdy_out = !valid || rdy_in;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy_out) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/elastic_delay_pipe.sv
// LATENCY-stage elastic delay line with bubble-collapsing backpressure and flush.
// Optional registered occupancy count when DELAY_OCC_EN is defined.
module elastic_delay_pipe
  import delay_pkg::*;
#(
  parameter int  LATENCY = DEFAULT_LATENCY,
  parameter int  WIDTH   = DEFAULT_WIDTH,
  parameter int  OCC_W   = clog2_p1(LATENCY),
  localparam int OCC_PW  = (OCC_W > 0) ? OCC_W : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
`ifdef DELAY_OCC_EN
  ,
  output logic [OCC_PW-1:0] occupancy
`endif
);

  // Handshake: a word moves across a port on a cycle where valid && ready are
  // both high at the posedge; ready may depend combinationally on downstream
  // ready, valid never depends on ready, and a held word stays stable.

  if (LATENCY == 0) begin : g_bypass
    assign in_ready  = out_ready && !flush;
    assign out_valid = in_valid && !flush;
    assign out_data  = in_data;
`ifdef DELAY_OCC_EN
    assign occupancy = '0;
`endif
  end else begin : g_pipe
    logic [LATENCY:0]   rdy;
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] v_in;
    logic [WIDTH-1:0]   d [LATENCY];

    // v_in[i] is the valid presented to stage i: in_valid for the head, else v[i-1].
    assign v_in         = LATENCY'({v, in_valid});
    assign rdy[LATENCY] = out_ready;
    assign in_ready     = rdy[0] && !flush;
    assign out_valid    = v[LATENCY-1];
    assign out_data     = d[LATENCY-1];

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      logic [WIDTH-1:0] pd;
      if (i == 0) begin : g_head
        assign pd = in_data;
      end else begin : g_body
        assign pd = d[i-1];
      end

      elastic_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .prev_valid(v_in[i]),
        .prev_data (pd),
        .rdy_in    (rdy[i+1]),
        .rdy_out   (rdy[i]),
        .valid     (v[i]),
        .data      (d[i])
      );
    end

`ifdef DELAY_OCC_EN
    logic [LATENCY-1:0] v_nxt;
    logic [OCC_W-1:0]   occ_cnt;
    logic [OCC_W-1:0]   occ_q;

    // Count the valids each stage will hold after this edge.
    always_comb begin
      v_nxt   = v;
      occ_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
        if (flush) begin
          v_nxt[i] = 1'b0;
        end else if (rdy[i]) begin
          v_nxt[i] = v_in[i];
        end
        occ_cnt = occ_cnt + OCC_W'(v_nxt[i]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_cnt;
      end
    end

    assign occupancy = occ_q;
`endif
  end

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// Bench for elastic_delay_pipe (LATENCY=4 and LATENCY=0 bypass, WIDTH=8) against
// a positional queue model; occupancy is compared when DELAY_OCC_EN is defined.
module tb_elastic_delay_pipe;
  localparam int L = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic         ir0, ov0;
  logic [W-1:0] od0;
`ifdef DELAY_OCC_EN
  logic [2:0]   occ;
  logic         occ0;
`endif

  int errors = 0;
  int checks = 0;

  // Model: exp_q holds payloads oldest first, pos_q the stage each one sits in.
  logic [W-1:0] exp_q[$];
  int           pos_q[$];
  logic [W-1:0] nxt_d[$];
  int           nxt_q[$];
  bit           after_reset;

  always #5 clk = ~clk;

  elastic_delay_pipe #(.LATENCY(L), .WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef DELAY_OCC_EN
    , .occupancy(occ)
`endif
  );

  elastic_delay_pipe #(.LATENCY(0), .WIDTH(W)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
`ifdef DELAY_OCC_EN
    , .occupancy(occ0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check at negedge, advance the model at the posedge.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl,
                      output bit acc);
    bit exp_ov, exp_ir, pop;
    int lim;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_ov = (pos_q.size() > 0) && (pos_q[0] == L - 1);
    pop = exp_ov && ordy;
    nxt_q = pos_q;
    nxt_d = exp_q;
    if (pop) begin
      void'(nxt_q.pop_front());
      void'(nxt_d.pop_front());
    end
    lim = L;
    foreach (nxt_q[k]) begin
      if (nxt_q[k] + 1 < lim) nxt_q[k] = nxt_q[k] + 1;
      lim = nxt_q[k];
    end
    exp_ir = !fl && (nxt_q.size() == 0 || nxt_q[nxt_q.size() - 1] > 0);

    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    if (after_reset) chk("reset_out_data", {24'd0, out_data}, 32'd0);
`ifdef DELAY_OCC_EN
    chk("occupancy", {29'd0, occ}, exp_q.size());
    chk("bypass_occupancy", {31'd0, occ0}, 32'd0);
`endif
    chk("bypass_out_valid", {31'd0, ov0}, {31'd0, iv && !fl});
    chk("bypass_out_data", {24'd0, od0}, {24'd0, id});
    chk("bypass_in_ready", {31'd0, ir0}, {31'd0, ordy && !fl});

    acc = iv && exp_ir && rstn;
    @(posedge clk);
    if (!rstn || fl) begin
      exp_q.delete();
      pos_q.delete();
    end else begin
      exp_q = nxt_d;
      pos_q = nxt_q;
      if (acc) begin
        exp_q.push_back(id);
        pos_q.push_back(0);
      end
    end
    after_reset = !rstn;
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), ordy, 1'b0, a);
  endtask

  initial begin
    bit a;
    int k;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    after_reset = 1'b0;
    @(posedge clk); #1;
    after_reset = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    rstn = 1'b1;

    // Back-to-back stream with free-running output.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0, a);
    idle(6, 1'b1);

    // Stall until full, then release; the source holds its word until accepted.
    k = 0;
    for (int c = 0; c < 16; c++) begin
      step(k < 6, 8'hA0 + W'(k), c >= 6, 1'b0, a);
      if (a) k++;
    end
    idle(4, 1'b1);

    // Bubbles under stall collapse.
    for (int c = 0; c < 8; c++) step(c % 2 == 0, 8'hB0 + W'(c), 1'b0, 1'b0, a);
    idle(6, 1'b1);

    // Full pipe with simultaneous push and pop.
    for (int c = 0; c < 4; c++) step(1'b1, 8'hC0 + W'(c), 1'b0, 1'b0, a);
    for (int c = 0; c < 8; c++) step(1'b1, 8'hD0 + W'(c), 1'b1, 1'b0, a);
    idle(6, 1'b1);

    // Flush with three words inside and a word offered during the flush.
    for (int c = 0; c < 3; c++) step(1'b1, 8'hE0 + W'(c), 1'b0, 1'b0, a);
    step(1'b1, 8'hEE, 1'b0, 1'b1, a);
    idle(6, 1'b1);

    // Reset mid-stream.
    for (int c = 0; c < 3; c++) step(1'b1, 8'hF0 + W'(c), 1'b0, 1'b0, a);
    rstn = 1'b0;
    step(1'b1, 8'h5A, 1'b1, 1'b0, a);
    rstn = 1'b1;
    idle(3, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      rstn = ($urandom_range(0, 49) != 0);
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, a);
    end
    rstn = 1'b1;
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
